// File: rtl/valid_strobe_gen_pkg.sv
// Shared encodings and period-limit lookup for the valid strobe generator.
// Pure declarations: no latency and no flow control.
package valid_strobe_pkg;

  localparam int NB_SEL = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  // Wide arguments let callers of any counter width size-cast the result.
  function automatic logic [63:0] limit_of(
    input logic [NB_SEL-1:0] sel,
    input logic [63:0]       l0,
    input logic [63:0]       l1,
    input logic [63:0]       l2,
    input logic [63:0]       l3
  );
    case (sel)
      2'd0:    limit_of = l0;
      2'd1:    limit_of = l1;
      2'd2:    limit_of = l2;
      default: limit_of = l3;
    endcase
  endfunction

endpackage

// File: rtl/valid_strobe_gen_period_counter.sv
// Free-running period counter, wrap pulse registered one edge after count==limit.
// Latency: o_wrap is high for the cycle after the wrap edge; no backpressure, i_clear wins.
module period_counter #(
  parameter int NB_COUNTER = 32
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_run,
  input  logic [NB_COUNTER-1:0] i_limit,
  output logic                  o_wrap,
  output logic [NB_COUNTER-1:0] o_count
);

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_count <= '0;
      o_wrap  <= 1'b0;
    end else if (i_clear || !i_run) begin
      o_count <= '0;
      o_wrap  <= 1'b0;
    end else if (o_count == i_limit) begin
      o_count <= '0;
      o_wrap  <= 1'b1;
    end else begin
      o_count <= o_count + NB_COUNTER'(1);
      o_wrap  <= 1'b0;
    end
  end

endmodule

// File: rtl/valid_strobe_gen.sv
// Advance-strobe generator for the LED shift register: continuous or N-strobe burst.
// Latency: first strobe LIMIT+1 clocks after leaving IDLE; no backpressure, i_enable=0 aborts.
module valid_strobe_gen
  import valid_strobe_pkg::*;
#(
  parameter int          NB_COUNTER = 32,
  parameter int unsigned LIMIT_0    = 12_500_000,
  parameter int unsigned LIMIT_1    = 25_000_000,
  parameter int unsigned LIMIT_2    = 50_000_000,
  parameter int unsigned LIMIT_3    = 100_000_000,
  parameter int          NB_BURST   = 4
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [NB_SEL-1:0]   i_sel,
  input  logic                i_burst,
  input  logic                i_start,
  input  logic [NB_BURST-1:0] i_burst_len,
  output logic                o_valid,
  output logic                o_busy,
  output logic [NB_SEL-1:0]   o_sel_active
);

  logic [1:0]            state;
  logic [NB_BURST-1:0]   remaining;
  logic [NB_COUNTER-1:0] count;
  logic [NB_COUNTER-1:0] limit;
  logic                  at_limit;
  logic                  counting;
  logic                  abort;

  assign limit    = NB_COUNTER'(limit_of(o_sel_active, 64'(LIMIT_0), 64'(LIMIT_1),
                                         64'(LIMIT_2), 64'(LIMIT_3)));
  assign at_limit = (count == limit);
  assign counting = (state != ST_IDLE);
  assign abort    = counting && !i_enable;

  period_counter #(
    .NB_COUNTER (NB_COUNTER)
  ) u_period_counter (
    .clock   (clock),
    .i_reset (i_reset),
    .i_clear (abort),
    .i_run   (counting),
    .i_limit (limit),
    .o_wrap  (o_valid),
    .o_count (count)
  );

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      o_sel_active <= '0;
      o_busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_enable && !i_burst) begin
            state        <= ST_RUN;
            o_busy       <= 1'b1;
            o_sel_active <= i_sel;
          end else if (i_enable && i_burst && i_start && (i_burst_len != '0)) begin
            state        <= ST_BURST;
            o_busy       <= 1'b1;
            remaining    <= i_burst_len;
            o_sel_active <= i_sel;
          end
        end
        ST_RUN: begin
          if (!i_enable) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (at_limit) begin
            o_sel_active <= i_sel;
          end
        end
        ST_BURST: begin
          if (!i_enable) begin
            state     <= ST_IDLE;
            o_busy    <= 1'b0;
            remaining <= '0;
          end else if (at_limit) begin
            o_sel_active <= i_sel;
            remaining    <= remaining - NB_BURST'(1);
            // The last strobe of the burst and the return to IDLE share one edge.
            if (remaining == NB_BURST'(1)) begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_valid_strobe_gen.sv
// Directed bench for valid_strobe_gen with small period limits (3, 4, 5, 7).
// Edge numbering: edge 0 is the first posedge at which the trigger inputs are seen.
module tb_valid_strobe_gen;

  logic       clock;
  logic       i_reset;
  logic       i_enable;
  logic [1:0] i_sel;
  logic       i_burst;
  logic       i_start;
  logic [3:0] i_burst_len;
  logic       o_valid;
  logic       o_busy;
  logic [1:0] o_sel_active;

  int errors = 0;
  int checks = 0;

  logic [3:0] led;
  logic       led_clr;

  valid_strobe_gen #(
    .NB_COUNTER (32),
    .LIMIT_0    (3),
    .LIMIT_1    (4),
    .LIMIT_2    (5),
    .LIMIT_3    (7),
    .NB_BURST   (4)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_sel        (i_sel),
    .i_burst      (i_burst),
    .i_start      (i_start),
    .i_burst_len  (i_burst_len),
    .o_valid      (o_valid),
    .o_busy       (o_busy),
    .o_sel_active (o_sel_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Minimal 4-LED rotating shift register consuming o_valid as i_valid.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset)     led <= 4'b0001;
    else if (led_clr) led <= 4'b0001;
    else if (o_valid) led <= {led[2:0], led[3]};
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_enable = 1'b0; i_sel = 2'd0; i_burst = 1'b0;
    i_start = 1'b0; i_burst_len = 4'd0; led_clr = 1'b0;
    tick(); tick();
    checks++;
    if ({o_valid, o_busy, o_sel_active} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0000", {o_valid, o_busy, o_sel_active});
    end
    checks++;
    if (dut.count !== 32'd0) begin
      errors++;
      $display("FAIL reset_count got=%0d exp=0", dut.count);
    end
    i_reset = 1'b1;
    tick();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy got=%b exp=0", o_busy);
    end
  endtask

  task automatic test_continuous();
    logic exp_v;
    i_sel = 2'd0; i_burst = 1'b0; i_enable = 1'b1;
    for (int e = 0; e <= 13; e++) begin
      tick();
      exp_v = (e != 0) && (e % 4 == 0);
      checks++;
      if (o_valid !== exp_v) begin
        errors++;
        $display("FAIL cont_valid edge=%0d got=%b exp=%b", e, o_valid, exp_v);
      end
      checks++;
      if (o_busy !== 1'b1) begin
        errors++;
        $display("FAIL cont_busy edge=%0d got=%b exp=1", e, o_busy);
      end
    end
    i_enable = 1'b0;
    tick();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL cont_stop_busy got=%b exp=0", o_busy);
    end
  endtask

  task automatic test_sel_change();
    logic       exp_v;
    logic [1:0] exp_s;
    i_sel = 2'd0; i_burst = 1'b0; i_enable = 1'b1;
    for (int e = 0; e <= 25; e++) begin
      tick();
      if (e == 5) begin
        checks++;
        if (dut.count !== 32'd1) begin
          errors++;
          $display("FAIL selchg_count edge=5 got=%0d exp=1", dut.count);
        end
        i_sel = 2'd3;
      end
      exp_v = (e == 4) || (e == 8) || (e == 16) || (e == 24);
      exp_s = (e < 8) ? 2'd0 : 2'd3;
      checks++;
      if (o_valid !== exp_v) begin
        errors++;
        $display("FAIL selchg_valid edge=%0d got=%b exp=%b", e, o_valid, exp_v);
      end
      checks++;
      if (o_sel_active !== exp_s) begin
        errors++;
        $display("FAIL selchg_sel edge=%0d got=%0d exp=%0d", e, o_sel_active, exp_s);
      end
    end
    i_enable = 1'b0;
    tick();
  endtask

  task automatic test_burst();
    logic exp_v;
    logic exp_b;
    i_sel = 2'd1; i_burst = 1'b1; i_burst_len = 4'd3; i_enable = 1'b1; i_start = 1'b1;
    for (int e = 0; e <= 22; e++) begin
      tick();
      if (e == 0) i_start = 1'b0;
      exp_v = (e == 5) || (e == 10) || (e == 15);
      exp_b = (e < 15);
      checks++;
      if (o_valid !== exp_v) begin
        errors++;
        $display("FAIL burst_valid edge=%0d got=%b exp=%b", e, o_valid, exp_v);
      end
      checks++;
      if (o_busy !== exp_b) begin
        errors++;
        $display("FAIL burst_busy edge=%0d got=%b exp=%b", e, o_busy, exp_b);
      end
    end
    checks++;
    if (o_sel_active !== 2'd1) begin
      errors++;
      $display("FAIL burst_sel got=%0d exp=1", o_sel_active);
    end
    i_burst_len = 4'd0; i_start = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick();
      checks++;
      if ({o_busy, o_valid} !== 2'b00) begin
        errors++;
        $display("FAIL burst_len0 edge=%0d got=%b exp=00", e, {o_busy, o_valid});
      end
    end
    i_start = 1'b0; i_enable = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    logic exp_b;
    i_sel = 2'd0; i_burst = 1'b1; i_burst_len = 4'd1; i_enable = 1'b1; i_start = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      tick();
      exp_v = (e == 4) || (e == 9) || (e == 14);
      exp_b = !exp_v;
      checks++;
      if (o_valid !== exp_v) begin
        errors++;
        $display("FAIL b2b_valid edge=%0d got=%b exp=%b", e, o_valid, exp_v);
      end
      checks++;
      if (o_busy !== exp_b) begin
        errors++;
        $display("FAIL b2b_busy edge=%0d got=%b exp=%b", e, o_busy, exp_b);
      end
    end
    i_start = 1'b0; i_enable = 1'b0;
    tick(); tick();
  endtask

  task automatic test_abort();
    i_sel = 2'd2; i_burst = 1'b0; i_enable = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick();
      checks++;
      if (dut.count !== 32'(e)) begin
        errors++;
        $display("FAIL abort_count edge=%0d got=%0d exp=%0d", e, dut.count, e);
      end
    end
    i_enable = 1'b0;
    for (int e = 6; e <= 8; e++) begin
      tick();
      checks++;
      if ({o_valid, o_busy} !== 2'b00) begin
        errors++;
        $display("FAIL abort_out edge=%0d got=%b exp=00", e, {o_valid, o_busy});
      end
      checks++;
      if (dut.count !== 32'd0) begin
        errors++;
        $display("FAIL abort_count_clr edge=%0d got=%0d exp=0", e, dut.count);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic exp_v;
    i_sel = 2'd1; i_burst = 1'b1; i_burst_len = 4'd3; i_enable = 1'b1; i_start = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 0) i_start = 1'b0;
    end
    checks++;
    if (dut.remaining !== 4'd2) begin
      errors++;
      $display("FAIL rst_remaining_pre got=%0d exp=2", dut.remaining);
    end
    #2;
    i_reset = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_busy, o_sel_active} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async_out got=%b exp=0000", {o_valid, o_busy, o_sel_active});
    end
    checks++;
    if (dut.remaining !== 4'd0) begin
      errors++;
      $display("FAIL rst_async_remaining got=%0d exp=0", dut.remaining);
    end
    i_burst = 1'b0;
    #2;
    i_reset = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick();
      exp_v = (e == 5);
      checks++;
      if (o_valid !== exp_v) begin
        errors++;
        $display("FAIL rst_run_valid edge=%0d got=%b exp=%b", e, o_valid, exp_v);
      end
      checks++;
      if (o_busy !== 1'b1) begin
        errors++;
        $display("FAIL rst_run_busy edge=%0d got=%b exp=1", e, o_busy);
      end
    end
    i_enable = 1'b0;
    tick();
  endtask

  task automatic test_integration();
    int         steps;
    logic [3:0] exp_led;
    logic [3:0] one;
    one = 4'b0001;
    led_clr = 1'b1;
    tick();
    led_clr = 1'b0;
    checks++;
    if (led !== 4'b0001) begin
      errors++;
      $display("FAIL integ_led_init got=%b exp=0001", led);
    end
    i_sel = 2'd0; i_burst = 1'b0; i_enable = 1'b1;
    for (int e = 0; e <= 21; e++) begin
      tick();
      steps   = (e >= 5) ? (e - 1) / 4 : 0;
      exp_led = one << (steps % 4);
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL integ_led edge=%0d got=%b exp=%b", e, led, exp_led);
      end
    end
    i_enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_sel_change();
    test_burst();
    test_back_to_back();
    test_abort();
    test_reset_mid_burst();
    test_integration();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
